apb_dpmem_param: RTL

Parametrised successor to the fixed-size APB dual-port memory slave. An APB4 completer (port A) and a native synchronous read/write port (port B) share one word-organised memory. Port B serves the datapath side.
- Adds to the previous generation: configurable width, depth, wait states and read-only window; byte-address decode with misalignment and out-of-range errors; port-B collision arbitration.

---
 rtl/apb_dpmem_param_pkg.sv | 25 ++
 rtl/apb_dpmem_param_dpram_be.sv | 59 +++++
 rtl/apb_dpmem_param.sv | 114 +++++++++++
 3 files changed

// File: rtl/apb_dpmem_param_pkg.sv
// Shared types and elaboration helpers for the APB dual-port memory slave.
// Provides the bus-phase enum, address-decode helpers and the wait-counter width.
package apb_dpmem_param_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_fsm_e;

    // Wait states are limited to 0..15.
    localparam int CNT_W = 4;

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // An empty window (lo > hi) never hits.
    function automatic logic ro_hit(input int unsigned idx,
                                    input int unsigned lo,
                                    input int unsigned hi);
        return (lo <= hi) && (idx >= lo) && (idx <= hi);
    endfunction

endpackage

// File: rtl/apb_dpmem_param_dpram_be.sv
// True dual-port, read-first word RAM with byte enables on port A.
// Port A (APB side) wins a same-word write collision; the port-B write is dropped.
module dpram_be #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 256,
    localparam int IDX_W      = $clog2(MEM_DEPTH),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_we,
    input  logic [IDX_W-1:0]      a_idx,
    input  logic [STRB_W-1:0]     a_be,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [IDX_W-1:0]      b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_collision
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  b_write;
    logic                  collide;

    assign b_write = b_en && b_we;
    assign collide = a_we && b_write && (a_idx == b_addr);
    assign a_rdata = mem[a_idx];

    // NOTE: storage has no reset branch so it maps onto plain RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (b_write && !collide) begin
            mem[b_addr] <= b_wdata;
        end
        if (a_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (a_be[i]) begin
                    mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignment makes b_rdata sample mem before this edge's writes land (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            b_rdata     <= '0;
            b_collision <= 1'b0;
        end else begin
            b_collision <= collide;
            if (b_en && !b_we) begin
                b_rdata <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/apb_dpmem_param.sv
// APB4 completer plus native port B sharing one word-organised memory.
// Holds the bus FSM, byte-address decode with error response, and the wait counter.
module apb_dpmem_param
    import apb_dpmem_param_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 16,
    parameter int          MEM_DEPTH  = 256,
    parameter int          RD_WAIT    = 1,
    parameter int          WR_WAIT    = 3,
    parameter int unsigned RO_LO      = 0,
    parameter int unsigned RO_HI      = 15
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    output logic                         PREADY,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PSLVERR,
    input  logic                         b_en,
    input  logic                         b_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]        b_wdata,
    output logic [DATA_WIDTH-1:0]        b_rdata,
    output logic                         b_collision
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LSB   = addr_lsb(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    apb_fsm_e              state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  misaligned, out_of_range, ro_write, no_strobe, err;
    logic                  commit;
    logic [DATA_WIDTH-1:0] a_rdata;

    // Decode runs on the live bus; APB keeps PADDR/PWRITE/PSTRB stable across the transfer.
    assign word_idx     = PADDR >> LSB;
    assign misaligned   = |(PADDR & ALIGN_MASK);
    assign out_of_range = {1'b0, word_idx} >= (ADDR_WIDTH + 1)'(MEM_DEPTH);
    assign ro_write     = PWRITE && ro_hit(32'(word_idx), RO_LO, RO_HI);
    assign no_strobe    = PWRITE && (PSTRB == '0);
    assign err          = misaligned || out_of_range || ro_write || no_strobe;

    // Error transfers complete on the first ACCESS cycle regardless of the counter.
    assign PREADY  = (state == ACCESS) && ((cnt == '0) || err);
    assign PSLVERR = PREADY && err;
    assign PRDATA  = (PREADY && !PWRITE && !err) ? a_rdata : '0;
    assign commit  = PREADY && PWRITE && !err && !PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) state_nxt = SETUP;
            end
            SETUP: begin
                if (PSEL && PENABLE) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = PWRITE ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
                end
            end
            ACCESS: begin
                if (PREADY) begin
                    state_nxt = (PSEL && !PENABLE) ? SETUP : IDLE;
                end else if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    dpram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk         (PCLK),
        .rst         (PRESET),
        .a_we        (commit),
        .a_idx       (word_idx[IDX_W-1:0]),
        .a_be        (PSTRB),
        .a_wdata     (PWDATA),
        .a_rdata     (a_rdata),
        .b_en        (b_en),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_rdata     (b_rdata),
        .b_collision (b_collision)
    );

endmodule
